// File: rtl/rca64_core.sv
// rca64_core: registered WIDTH-bit ripple-carry adder, one-cycle latency.
// Define RCA64_FLAGS_EN to add registered ovf/zero flag outputs.
module rca64_core #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
`ifdef RCA64_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  logic [WIDTH-1:0] sum;
  logic             c_msb;

  // Each stage owns its carry nets so the chain is not one self-feeding vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic ci;
    logic co;
    if (i == 0) begin : g_lsb
      assign ci = cin;
    end else begin : g_mid
      assign ci = g_fa[i-1].co;
    end
    assign sum[i] = a[i] ^ b[i] ^ ci;
    assign co     = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
  end

  assign c_msb = g_fa[WIDTH-1].co;

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             vld_q, vld_d;

  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    vld_d  = in_valid;
    if (in_valid) begin
      s_d    = sum;
      cout_d = c_msb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;

`ifdef RCA64_FLAGS_EN
  logic c_pre;
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;

  assign c_pre = g_fa[WIDTH-1].ci;

  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (in_valid) begin
      ovf_d  = c_msb ^ c_pre;
      zero_d = (sum == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_rca64_core.sv
// tb_rca64_core: directed table, corner sequences and random regression
// for rca64_core against an arithmetic reference model.
module tb_rca64_core;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         cin, in_valid;
  logic [W-1:0] s;
  logic         cout, out_valid;
`ifdef RCA64_FLAGS_EN
  logic         ovf, zero;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  rca64_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .s         (s),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef RCA64_FLAGS_EN
    ,
    .ovf       (ovf),
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: widened integer sum plus sign-rule overflow.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic [W-1:0] r);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic v);
    @(negedge clk);
    a = x; b = y; cin = ci; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [W-1:0] es,
                         input logic ec, input logic ev);
    chk({name, ".sum"}, {63'd0, cout, s}, {63'd0, ec, es});
    chk({name, ".vld"}, {127'd0, out_valid}, {127'd0, ev});
  endtask

  task automatic chk_flags(input string name, input logic eo,
                           input logic ez);
`ifdef RCA64_FLAGS_EN
    chk({name, ".ovf"}, {127'd0, ovf}, {127'd0, eo});
    chk({name, ".zero"}, {127'd0, zero}, {127'd0, ez});
`else
    if (eo === 1'bx || ez === 1'bx) $display("note %s flags unknown", name);
`endif
  endtask

  vec_t vt[6];

  initial begin
    logic [W:0]   full;
    logic [W-1:0] ms, ra, rb;
    logic         mc, mo, mz, rc, rv;

    vt[0] = '{64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b0, 1'b0};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
              64'h0, 1'b1, 1'b0, 1'b1};
    vt[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
              64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vt[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
              64'h0, 1'b1, 1'b1, 1'b1};
    vt[4] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
    #1;
    chk_out("reset", 64'h0, 1'b0, 1'b0);
    chk_flags("reset", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].a, vt[i].b, vt[i].cin, 1'b1);
      chk_out($sformatf("tab%0d", i), vt[i].s, vt[i].cout, 1'b1);
      chk_flags($sformatf("tab%0d", i), vt[i].ovf, vt[i].zero);
    end

    drive(64'd1, 64'd2, 1'b0, 1'b1);
    chk_out("b2b0", 64'd3, 1'b0, 1'b1);
    drive(64'h1234, 64'h4321, 1'b1, 1'b1);
    chk_out("b2b1", 64'h5556, 1'b0, 1'b1);
    drive(64'hFFFF, 64'hFFFF, 1'b1, 1'b0);
    chk_out("hold", 64'h5556, 1'b0, 1'b0);

    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 64'h0, 1'b0, 1'b0);
    chk_flags("async_rst", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("rst_held", 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(64'd7, 64'd9, 1'b0, 1'b0);
    chk_out("post_rst_idle", 64'h0, 1'b0, 1'b0);
    drive(64'd7, 64'd9, 1'b0, 1'b1);
    chk_out("post_rst_cap", 64'd16, 1'b0, 1'b1);

    ms = 64'd16; mc = 1'b0; mo = 1'b0; mz = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 7))
        0: begin ra = '1; rb = {63'd0, 1'b1} << $urandom_range(0, 63); end
        1: begin ra = {1'b0, {63{1'b1}}}; rb = {$urandom, $urandom}; end
        default: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
      endcase
      rc = 1'($urandom);
      rv = ($urandom_range(0, 9) != 0);
      if (rv) begin
        full = ref_sum(ra, rb, rc);
        ms = full[W-1:0];
        mc = full[W];
        mo = ref_ovf(ra, rb, ms);
        mz = (ms == '0);
      end
      drive(ra, rb, rc, rv);
      chk_out("rand", ms, mc, rv);
      chk_flags("rand", mo, mz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
